// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a simple bus-based datapath. Steps through
// fetch (T0-T2) and execute (T3-T7) phases and produces the bus drive and
// register load strobes for each step. Supports ld, add, sub, and, or, nop
// and halt. Any unknown opcode runs as a nop.
//
// All outputs are decoded from the current state (and IR in T3-T7) only.
// mem_ready affects only the next-state logic, so it has no combinational
// path to any output.
//
// Ports
//   Clock      in   system clock, rising-edge active
//   clear      in   asynchronous active-low reset
//   IR[31:0]   in   instruction register: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   mem_ready  in   memory read data valid this cycle
//   PCout, Zlowout, MDRout, Cout         out  bus drive strobes (mutually exclusive)
//   MARin, Zin, PCin, MDRin, IRin, Yin   out  register load strobes
//   IncPC      out  ALU PC-increment select
//   Read       out  memory read request
//   alu_op[3:0] out 0 none, 1 ADD, 2 SUB, 3 AND, 4 OR
//   Rin[15:0]  out  one-hot general register load enables
//   Rout[15:0] out  one-hot general register bus drive enables
//   Run        out  high while sequencing, low once halted
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic [3:0]  alu_op,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        Run
);

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;

    // One-hot decode of a 4-bit register index.
    function automatic logic [15:0] reg_sel(input logic [3:0] idx);
        reg_sel = 16'd1 << idx;
    endfunction

    // ALU operation for an R-type opcode; none for anything else.
    function automatic logic [3:0] alu_for(input logic [4:0] op);
        case (op)
            OP_ADD:  alu_for = ALU_ADD;
            OP_SUB:  alu_for = ALU_SUB;
            OP_AND:  alu_for = ALU_AND;
            OP_OR:   alu_for = ALU_OR;
            default: alu_for = ALU_NONE;
        endcase
    endfunction

    state_t      state_q;
    state_t      state_d;
    // Set once T1 has already spent a cycle waiting, so PC is loaded only once.
    logic        wait_q;
    logic        wait_d;

    logic [4:0]  opcode_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [3:0]  rc_s;
    logic        is_rtype_s;
    logic        is_ld_s;
    logic        unused_ir_s;

    assign opcode_s    = IR[31:27];
    assign ra_s        = IR[26:23];
    assign rb_s        = IR[22:19];
    assign rc_s        = IR[18:15];
    assign unused_ir_s = ^IR[14:0];

    // Instruction class decode.
    always_comb begin
        is_rtype_s = 1'b0;
        is_ld_s    = 1'b0;
        case (opcode_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype_s = 1'b1;
            OP_LD:                         is_ld_s    = 1'b1;
            default: begin
                is_rtype_s = 1'b0;
                is_ld_s    = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1: begin
                if (mem_ready) begin
                    state_d = ST_T2;
                end else begin
                    state_d = ST_T1;
                end
            end
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (is_rtype_s || is_ld_s) begin
                    state_d = ST_T4;
                end else if (opcode_s == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if (is_ld_s) begin
                    state_d = ST_T6;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T6: begin
                if (mem_ready) begin
                    state_d = ST_T7;
                end else begin
                    state_d = ST_T6;
                end
            end
            ST_T7:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Wait flag: the next cycle is a repeat T1 cycle.
    always_comb begin
        if ((state_q == ST_T1) && (state_d == ST_T1)) begin
            wait_d = 1'b1;
        end else begin
            wait_d = 1'b0;
        end
    end

    // State and wait-flag registers; clear forces RST at once.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_RST;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Output decode from the current state (and IR during execute).
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        alu_op  = ALU_NONE;
        Rin     = 16'd0;
        Rout    = 16'd0;
        Run     = 1'b1;
        case (state_q)
            ST_RST: begin
                Run = 1'b1;
            end
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (!wait_q) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end else begin
                    Zlowout = 1'b0;
                    PCin    = 1'b0;
                end
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (is_rtype_s || is_ld_s) begin
                    Rout = reg_sel(rb_s);
                    Yin  = 1'b1;
                end else begin
                    Rout = 16'd0;
                    Yin  = 1'b0;
                end
            end
            ST_T4: begin
                if (is_ld_s) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = ALU_ADD;
                end else if (is_rtype_s) begin
                    Rout   = reg_sel(rc_s);
                    Zin    = 1'b1;
                    alu_op = alu_for(opcode_s);
                end else begin
                    alu_op = ALU_NONE;
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (is_ld_s) begin
                    MARin = 1'b1;
                end else begin
                    Rin = reg_sel(ra_s);
                end
            end
            ST_T6: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T7: begin
                MDRout = 1'b1;
                Rin    = reg_sel(ra_s);
            end
            ST_HALT: begin
                Run = 1'b0;
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Builds, per instruction, the expected list of per-cycle output vectors from
// the instruction's class and register fields, together with the mem_ready
// value to drive each cycle, then plays the list against the DUT. IR carries
// random values during fetch; mem_ready is random outside memory waits.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    typedef struct packed {
        logic        run;
        logic        pcout;
        logic        zlowout;
        logic        mdrout;
        logic        cout;
        logic        marin;
        logic        zin;
        logic        pcin;
        logic        mdrin;
        logic        irin;
        logic        yin;
        logic        incpc;
        logic        read;
        logic [3:0]  alu;
        logic [15:0] rin;
        logic [15:0] rout;
    } outv_t;

    typedef struct {
        outv_t       exp;
        logic        mr;
        logic        use_ir;
        logic [31:0] ir;
        int          phase;  // 0-7 = T0-T7, 9 = HALT, 10 = RST, 11 = async clear
    } step_t;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        PCout, Zlowout, MDRout, Cout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, Read, Run;
    logic [3:0]  alu_op;
    logic [15:0] Rin, Rout;

    step_t q[$];
    int    vectors;
    int    miscompares;

    control_sequencer dut (
        .Clock    (Clock),
        .clear    (clear),
        .IR       (IR),
        .mem_ready(mem_ready),
        .PCout    (PCout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .Cout     (Cout),
        .MARin    (MARin),
        .Zin      (Zin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .IncPC    (IncPC),
        .Read     (Read),
        .alu_op   (alu_op),
        .Rin      (Rin),
        .Rout     (Rout),
        .Run      (Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic outv_t idle();
        outv_t v;
        v     = '0;
        v.run = 1'b1;
        return v;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic check(input int phase, input outv_t exp);
        outv_t obs;
        obs = {Run, PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin,
               IRin, Yin, IncPC, Read, alu_op, Rin, Rout};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL phase%0d observed=%h expected=%h", phase, obs, exp);
        end
    endtask

    task automatic push(input outv_t v, input logic mr, input logic use_ir,
                        input logic [31:0] ir, input int phase);
        step_t s;
        s.exp    = v;
        s.mr     = mr;
        s.use_ir = use_ir;
        s.ir     = ir;
        s.phase  = phase;
        q.push_back(s);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction. w1/w6 are the
    // number of cycles memory stays not-ready in the fetch/operand reads.
    task automatic plan_instr(input logic [4:0] op, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [3:0] rc,
                              input int w1, input int w6);
        outv_t       v;
        logic [31:0] ir;
        logic        rt, ld, hl;
        ir = {op, ra, rb, rc, 15'($urandom)};
        rt = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6);
        ld = (op == 5'd0);
        hl = (op == 5'd27);

        v = idle(); v.pcout = 1'b1; v.marin = 1'b1; v.incpc = 1'b1; v.zin = 1'b1;
        push(v, rbit(), 1'b0, ir, 0);
        for (int i = 0; i <= w1; i++) begin
            v = idle(); v.read = 1'b1; v.mdrin = 1'b1;
            if (i == 0) begin
                v.zlowout = 1'b1;
                v.pcin    = 1'b1;
            end
            push(v, (i == w1), 1'b0, ir, 1);
        end
        v = idle(); v.mdrout = 1'b1; v.irin = 1'b1;
        push(v, rbit(), 1'b0, ir, 2);

        v = idle();
        if (rt || ld) begin
            v.rout = 16'd1 << rb;
            v.yin  = 1'b1;
        end
        push(v, rbit(), 1'b1, ir, 3);

        if (rt) begin
            v = idle(); v.rout = 16'd1 << rc; v.zin = 1'b1;
            v.alu = (op == 5'd3) ? 4'd1 : (op == 5'd4) ? 4'd2 : (op == 5'd5) ? 4'd3 : 4'd4;
            push(v, rbit(), 1'b1, ir, 4);
            v = idle(); v.zlowout = 1'b1; v.rin = 16'd1 << ra;
            push(v, rbit(), 1'b1, ir, 5);
        end
        if (ld) begin
            v = idle(); v.cout = 1'b1; v.zin = 1'b1; v.alu = 4'd1;
            push(v, rbit(), 1'b1, ir, 4);
            v = idle(); v.zlowout = 1'b1; v.marin = 1'b1;
            push(v, rbit(), 1'b1, ir, 5);
            for (int i = 0; i <= w6; i++) begin
                v = idle(); v.read = 1'b1; v.mdrin = 1'b1;
                push(v, (i == w6), 1'b1, ir, 6);
            end
            v = idle(); v.mdrout = 1'b1; v.rin = 16'd1 << ra;
            push(v, rbit(), 1'b1, ir, 7);
        end
        if (hl) begin
            for (int i = 0; i < 12; i++) begin
                push('0, rbit(), 1'b1, ir, 9);
            end
        end
    endtask

    // Play n queued cycles: drive inputs just after the edge, check, advance.
    task automatic run_n(input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s         = q.pop_front();
            mem_ready = s.mr;
            IR        = s.use_ir ? s.ir : $urandom;
            #1;
            check(s.phase, s.exp);
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    // Assert clear, check the immediate effect, release after one edge.
    task automatic do_reset();
        clear = 1'b0;
        #1;
        check(11, idle());
        @(posedge Clock);
        #1;
        check(10, idle());
        clear = 1'b1;
        q.delete();
        push(idle(), rbit(), 1'b0, 32'd0, 10);
    endtask

    initial begin
        step_t s;
        logic [4:0] op;
        vectors     = 0;
        miscompares = 0;
        clear       = 1'b1;
        IR          = 32'd0;
        mem_ready   = 1'b0;
        #3;

        // add R2,R3,R0 with memory ready immediately
        do_reset();
        plan_instr(5'd3, 4'd2, 4'd3, 4'd0, 0, 0);
        run_all();

        // fetch waits three cycles; PC loads only on the first T1 cycle
        plan_instr(5'd5, 4'd7, 4'd9, 4'd15, 3, 0);
        run_all();

        // ld R4,C(R1) with two not-ready cycles in the operand read
        plan_instr(5'd0, 4'd4, 4'd1, 4'd0, 0, 2);
        run_all();

        // illegal opcode behaves as nop
        plan_instr(5'd31, 4'd6, 4'd6, 4'd6, 1, 0);
        run_all();

        // same register in every field
        plan_instr(5'd3, 4'd5, 4'd5, 4'd5, 0, 0);
        run_all();

        // randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(7, 0))
                0:       op = 5'd0;
                1:       op = 5'd3;
                2:       op = 5'd4;
                3:       op = 5'd5;
                4:       op = 5'd6;
                5:       op = 5'd26;
                default: begin
                    op = 5'($urandom);
                    if (op == 5'd27) op = 5'd26;
                end
            endcase
            plan_instr(op, 4'($urandom), 4'($urandom), 4'($urandom),
                       $urandom_range(3, 0), $urandom_range(3, 0));
            run_all();
        end

        // clear in the middle of T4 of a sub
        do_reset();
        plan_instr(5'd4, 4'd8, 4'd10, 4'd12, 0, 0);
        run_n(5);
        s         = q.pop_front();
        IR        = s.ir;
        mem_ready = s.mr;
        #1;
        check(s.phase, s.exp);
        #2;
        clear = 1'b0;
        #1;
        check(11, idle());
        do_reset();
        plan_instr(5'd6, 4'd1, 4'd2, 4'd3, 0, 0);
        run_all();

        // clear while waiting in T1
        plan_instr(5'd3, 4'd1, 4'd1, 4'd1, 3, 0);
        run_n(3);
        #2;
        clear = 1'b0;
        #1;
        check(11, idle());
        do_reset();
        plan_instr(5'd26, 4'd0, 4'd0, 4'd0, 0, 0);
        run_all();

        // halt, stay halted, then recover through clear
        plan_instr(5'd27, 4'd0, 4'd0, 4'd0, 1, 0);
        run_all();
        do_reset();
        plan_instr(5'd26, 4'd3, 4'd3, 4'd3, 0, 0);
        run_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
